// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB slave in front of a word-organised on-chip SRAM/ROM.
// Byte lanes are big-endian (offset 0 on HWDATA/HRDATA [31:24]). Every OKAY
// data phase is stretched by WAIT_STATES cycles. Decode errors get the
// two-cycle ERROR response.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | no transfer in its data phase
//  WAIT  | OKAY transfer, HREADYOUT held low while cnt counts down
//  LAST  | final OKAY data-phase cycle; a pending write commits at its end
//  ERR1  | first ERROR cycle (HREADYOUT low)
//  ERR2  | second ERROR cycle (HREADYOUT high)
module ahb_sram_slave #(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 0,
    parameter bit READ_ONLY   = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int IDX_W = ADDR_BITS - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              slave_rdy;
    logic              accept, dec_err, accept_ok, accept_err;
    logic [3:0]        be_dec;
    logic [IDX_W-1:0]  idx_in;
    logic              wr_pend;
    logic [IDX_W-1:0]  wr_idx;
    logic [3:0]        wr_be;
    logic              commit;
    logic [31:0]       rd_word;
    logic [31:0]       mem [DEPTH];

    // Burst type, alias bits and the BUSY/IDLE distinction carry no information here.
    logic unused_bits;
    assign unused_bits = ^{HBURST, HADDR[31:ADDR_BITS], HTRANS[0]};

    // Our own ready gates acceptance so a stray HREADY during WAIT/ERR1 cannot restart us.
    assign slave_rdy  = (state != ST_WAIT) && (state != ST_ERR1);
    assign HREADYOUT  = slave_rdy;
    assign HRESP      = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;

    assign accept     = HSEL & HREADY & HTRANS[1] & slave_rdy;
    assign idx_in     = HADDR[ADDR_BITS-1:2];
    assign accept_ok  = accept & ~dec_err;
    assign accept_err = accept & dec_err;
    assign commit     = (state == ST_LAST) & wr_pend;

    // Address-phase decode: transfer legality and big-endian byte enables.
    always_comb begin
        dec_err = 1'b0;
        be_dec  = 4'b0000;
        case (HSIZE)
            3'b000:  be_dec = 4'b1000 >> HADDR[1:0];
            3'b001:  begin
                be_dec  = HADDR[1] ? 4'b0011 : 4'b1100;
                dec_err = HADDR[0];
            end
            3'b010:  begin
                be_dec  = 4'b1111;
                dec_err = (HADDR[1:0] != 2'b00);
            end
            default: dec_err = 1'b1;
        endcase
        if (READ_ONLY && HWRITE)
            dec_err = 1'b1;
    end

    // Read word for a new accept, with a write ending this same edge merged in.
    always_comb begin
        rd_word = mem[idx_in];
        if (commit && (wr_idx == idx_in)) begin
            for (int i = 0; i < 4; i++)
                if (wr_be[i])
                    rd_word[i*8 +: 8] = HWDATA[i*8 +: 8];
        end
    end

    // Next-state logic; wait counter is a down-counter with terminal count at 1.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nx = ST_LAST;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_ERR1: state_nx = ST_ERR2;
            default: begin
                state_nx = ST_IDLE;
                if (accept_ok) begin
                    if (WAIT_STATES > 0) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = WS_LOAD;
                    end else begin
                        state_nx = ST_LAST;
                    end
                end else if (accept_err) begin
                    state_nx = ST_ERR1;
                end
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Transfer bookkeeping: pending write capture and read data launch.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_pend <= 1'b0;
            wr_idx  <= '0;
            wr_be   <= 4'b0000;
            HRDATA  <= 32'd0;
        end else if (accept_ok) begin
            wr_pend <= HWRITE;
            wr_idx  <= idx_in;
            wr_be   <= be_dec;
            if (!HWRITE)
                HRDATA <= rd_word;
        end else if (slave_rdy) begin
            wr_pend <= 1'b0;
        end
    end

    // Storage: only enabled lanes change; contents survive reset.
    always_ff @(posedge HCLK) begin
        if (commit && !HRESET) begin
            for (int i = 0; i < 4; i++)
                if (wr_be[i])
                    mem[wr_idx][i*8 +: 8] <= HWDATA[i*8 +: 8];
        end
    end

endmodule
